// File: rtl/fc_weight_dma_if.sv
// Bus bundle between the FC layer controller, the weight memory and the weight DMA.
// DMA_read is a level request sampled only while the engine is idle; DMA_ready is a one-cycle pulse coincident with word 0 on the stream.
interface fc_weight_dma_if #(
  parameter int MEM_ADDRESS_WIDTH   = 16,
  parameter int LAYER_ADDRESS_WIDTH = 7,
  parameter int DATA_WIDTH          = 16
);
  logic                           DMA_read;
  logic [MEM_ADDRESS_WIDTH-1:0]   DMA_address;
  logic [LAYER_ADDRESS_WIDTH-1:0] DMA_count;
  logic                           DMA_ready;
  logic                           mem_en;
  logic [MEM_ADDRESS_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]          mem_rdata;
  logic [DATA_WIDTH-1:0]          stream_data;
  logic                           stream_valid;
  logic                           stream_last;
  logic [LAYER_ADDRESS_WIDTH-1:0] stream_index;
  logic                           busy;

  modport slave (
    input  DMA_read, DMA_address, DMA_count, mem_rdata,
    output DMA_ready, mem_en, mem_addr, stream_data, stream_valid,
           stream_last, stream_index, busy
  );

  modport master (
    output DMA_read, DMA_address, DMA_count, mem_rdata,
    input  DMA_ready, mem_en, mem_addr, stream_data, stream_valid,
           stream_last, stream_index, busy
  );
endinterface

// File: rtl/fc_weight_dma.sv
// Weight/bias DMA: burst-reads a block of words from synchronous memory into a local
// buffer, then streams it one word per cycle onto the FC data bus.
module fc_weight_dma #(
  parameter int MEM_ADDRESS_WIDTH   = 16,
  parameter int LAYER_ADDRESS_WIDTH = 7,
  parameter int DATA_WIDTH          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  fc_weight_dma_if.slave bus,
  output logic [1:0] dbg_state
);
  localparam int DEPTH = 2 ** LAYER_ADDRESS_WIDTH;
  localparam logic [LAYER_ADDRESS_WIDTH-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, STREAM} state_t;
  state_t state, state_next;

  logic [MEM_ADDRESS_WIDTH-1:0]   base;
  logic [LAYER_ADDRESS_WIDTH-1:0] len, fetch_cnt, cap_cnt;
  logic                           cap_pending;
  logic [DATA_WIDTH-1:0]          wbuf [DEPTH];

  logic                           mem_en_c;
  logic [MEM_ADDRESS_WIDTH-1:0]   mem_addr_c;
  logic                           accept;
  logic [LAYER_ADDRESS_WIDTH-1:0] rd_idx;
  logic [DATA_WIDTH-1:0]          rd_data;

  logic                           ready_q, valid_q, last_q;
  logic [LAYER_ADDRESS_WIDTH-1:0] index_q;
  logic [DATA_WIDTH-1:0]          data_q;

  assign accept = (state == IDLE) && bus.DMA_read && (bus.DMA_count != '0);

  always_ff @(posedge clk) begin
    if (rst)         state <= IDLE;
    else if (clk_en) state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_en_c   = 1'b0;
    mem_addr_c = '0;
    case (state)
      IDLE:   if (accept) state_next = FETCH;
      FETCH: begin
        mem_en_c   = clk_en;
        mem_addr_c = base + MEM_ADDRESS_WIDTH'(fetch_cnt);
        if (fetch_cnt == len - ONE) state_next = DRAIN;
      end
      DRAIN:  state_next = STREAM;
      STREAM: if (last_q) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture runs off the previous cycle's mem_en regardless of clk_en, so no issued read is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_pending <= 1'b0;
      cap_cnt     <= '0;
    end else begin
      cap_pending <= mem_en_c;
      if (cap_pending)        cap_cnt <= cap_cnt + ONE;
      else if (state == IDLE) cap_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_pending) wbuf[cap_cnt] <= bus.mem_rdata;
  end

  // For a one-word burst, word 0 lands in the same edge that loads it onto the stream.
  assign rd_idx  = (state == STREAM) ? index_q + ONE : '0;
  assign rd_data = (cap_pending && (cap_cnt == rd_idx)) ? bus.mem_rdata : wbuf[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      base      <= '0;
      len       <= '0;
      fetch_cnt <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      index_q   <= '0;
      data_q    <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: if (accept) begin
          base      <= bus.DMA_address;
          len       <= bus.DMA_count;
          fetch_cnt <= '0;
        end
        FETCH: fetch_cnt <= fetch_cnt + ONE;
        DRAIN: begin
          valid_q <= 1'b1;
          ready_q <= 1'b1;
          index_q <= '0;
          data_q  <= rd_data;
          last_q  <= (len == ONE);
        end
        STREAM: begin
          if (last_q) begin
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            index_q <= '0;
            data_q  <= '0;
          end else begin
            valid_q <= 1'b1;
            ready_q <= 1'b0;
            index_q <= rd_idx;
            data_q  <= rd_data;
            last_q  <= (rd_idx == len - ONE);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_en       = mem_en_c;
  assign bus.mem_addr     = mem_addr_c;
  assign bus.DMA_ready    = ready_q;
  assign bus.stream_valid = valid_q;
  assign bus.stream_last  = last_q;
  assign bus.stream_index = index_q;
  assign bus.stream_data  = data_q;
  assign bus.busy         = (state != IDLE);
  assign dbg_state        = state;
endmodule

// File: tb/tb_fc_weight_dma.sv
// Scoreboarded bench for fc_weight_dma: memory holds mem[a] = a, expected addresses and
// stream words are queued when a burst is driven and popped as the DUT produces them.
module tb_fc_weight_dma;
  localparam int MAW = 16;
  localparam int LAW = 7;
  localparam int DW  = 16;
  localparam int EW  = 1 + LAW + DW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b1;
  logic [1:0] dbg_state;

  fc_weight_dma_if #(.MEM_ADDRESS_WIDTH(MAW), .LAYER_ADDRESS_WIDTH(LAW), .DATA_WIDTH(DW)) bus ();

  fc_weight_dma #(.MEM_ADDRESS_WIDTH(MAW), .LAYER_ADDRESS_WIDTH(LAW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus.slave), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / memory model ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [2**MAW];
  initial begin
    for (int a = 0; a < 2**MAW; a++) mem[a] = DW'(a);
    bus.mem_rdata = '0;
  end
  always @(posedge clk) if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];

  // ---------------- scoreboard ----------------
  logic [EW-1:0]  exp_q[$];
  logic [MAW-1:0] addr_q[$];
  int checks = 0;
  int errors = 0;

  int men_first, men_last, men_count, ready_cyc, last_cyc;
  bit last_seen;

  always @(negedge clk) begin
    logic [EW-1:0]  e;
    logic [MAW-1:0] a;
    if (bus.mem_en === 1'b1) begin
      men_count++;
      if (men_first < 0) men_first = cyc;
      men_last = cyc;
      checks++;
      if (clk_en !== 1'b1) begin
        errors++;
        $display("FAIL mem_en_gate: mem_en=1 while clk_en=%0b at cycle %0d", clk_en, cyc);
      end
      checks++;
      if (addr_q.size() == 0) begin
        errors++;
        $display("FAIL mem_addr_unexpected: got %h with no read expected at cycle %0d", bus.mem_addr, cyc);
      end else begin
        a = addr_q.pop_front();
        if (bus.mem_addr !== a) begin
          errors++;
          $display("FAIL mem_addr: got %h expected %h at cycle %0d", bus.mem_addr, a, cyc);
        end
      end
    end
    if (clk_en === 1'b1 && bus.stream_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_unexpected: data=%h index=%0d at cycle %0d", bus.stream_data, bus.stream_index, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({bus.stream_last, bus.stream_index, bus.stream_data} !== e) begin
          errors++;
          $display("FAIL stream_word: got last=%b idx=%0d data=%h expected last=%b idx=%0d data=%h",
                   bus.stream_last, bus.stream_index, bus.stream_data, e[EW-1], e[EW-2:DW], e[DW-1:0]);
        end
        checks++;
        if (bus.DMA_ready !== (e[EW-2:DW] == '0)) begin
          errors++;
          $display("FAIL dma_ready: got %b expected %b at index %0d", bus.DMA_ready, (e[EW-2:DW] == '0), e[EW-2:DW]);
        end
      end
      if (bus.DMA_ready === 1'b1) ready_cyc = cyc;
      if (bus.stream_last === 1'b1) begin
        last_cyc  = cyc;
        last_seen = 1'b1;
      end
    end
    if (bus.stream_valid !== 1'b1 && (bus.DMA_ready === 1'b1 || bus.stream_last === 1'b1)) begin
      checks++;
      errors++;
      $display("FAIL stray_pulse: ready=%b last=%b without valid at cycle %0d", bus.DMA_ready, bus.stream_last, cyc);
    end
  end

  // ---------------- driver ----------------
  // Runs one burst; s1/s2 start 3-cycle clk_en stalls at that cycle offset (0 = none);
  // hold keeps DMA_read high and switches DMA_address to next_addr once ready is seen;
  // rst_word >= 0 asserts rst while that stream index is presented.
  task automatic do_burst(input logic [MAW-1:0] addr, input logic [LAW-1:0] cnt,
                          input int s1, input int s2, input bit hold,
                          input logic [MAW-1:0] next_addr, input int rst_word,
                          output int c0, output bit aborted);
    int k;
    logic [MAW-1:0] a;
    men_first = -1; men_last = -1; men_count = 0;
    ready_cyc = -1; last_cyc = -1; last_seen = 1'b0;
    aborted = 1'b0;
    if (bus.DMA_read !== 1'b1) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < int'(cnt); i++) begin
      a = addr + MAW'(i);
      addr_q.push_back(a);
      if (rst_word < 0 || i <= rst_word)
        exp_q.push_back({(i == int'(cnt) - 1), LAW'(i), mem[a]});
    end
    bus.DMA_read    = 1'b1;
    bus.DMA_address = addr;
    bus.DMA_count   = cnt;
    clk_en          = 1'b1;
    c0 = cyc;
    k = 0;
    while (!last_seen && k < 1000) begin
      @(posedge clk); #1;
      k++;
      if (!hold) bus.DMA_read = 1'b0;
      if (hold && ready_cyc >= 0) bus.DMA_address = next_addr;
      clk_en = !((s1 > 0 && k >= s1 && k < s1 + 3) || (s2 > 0 && k >= s2 && k < s2 + 3));
      if (rst_word >= 0 && bus.stream_valid === 1'b1 && int'(bus.stream_index) == rst_word) begin
        rst = 1'b1;
        @(posedge clk); #1;
        aborted = 1'b1;
        break;
      end
    end
    if (!last_seen && !aborted) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: no stream_last within 1000 cycles for addr %h count %0d", addr, cnt);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: %0d words and %0d reads still expected", name, exp_q.size(), addr_q.size());
    end
    exp_q.delete();
    addr_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.DMA_read = 1'b0; bus.DMA_address = '0; bus.DMA_count = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.DMA_ready, bus.mem_en, bus.stream_valid, bus.stream_last, bus.busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: ready/mem_en/valid/last/busy = %b expected 00000",
               {bus.DMA_ready, bus.mem_en, bus.stream_valid, bus.stream_last, bus.busy});
    end
    checks++;
    if ({bus.mem_addr, bus.stream_data, bus.stream_index} !== '0) begin
      errors++;
      $display("FAIL reset_values: mem_addr=%h data=%h index=%0d expected 0", bus.mem_addr, bus.stream_data, bus.stream_index);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int c0; bit ab;
    do_burst(16'd0, 7'd121, 0, 0, 1'b0, 16'd0, -1, c0, ab);
    checks++;
    if (men_first != c0 + 1 || men_last != c0 + 121 || men_count != 121) begin
      errors++;
      $display("FAIL basic_fetch: mem_en cycles %0d..%0d count %0d expected %0d..%0d count 121",
               men_first - c0, men_last - c0, men_count, 1, 121);
    end
    checks++;
    if (ready_cyc != c0 + 123) begin
      errors++;
      $display("FAIL basic_ready_time: got +%0d expected +123", ready_cyc - c0);
    end
    checks++;
    if (last_cyc != c0 + 243) begin
      errors++;
      $display("FAIL basic_last_time: got +%0d expected +243", last_cyc - c0);
    end
    check_drained("basic");
  endtask

  task automatic test_back_to_back();
    int c0, c1, prev_last; bit ab;
    do_burst(16'd0, 7'd121, 0, 0, 1'b1, 16'd121, -1, c0, ab);
    prev_last = last_cyc;
    do_burst(16'd121, 7'd121, 0, 0, 1'b0, 16'd0, -1, c1, ab);
    checks++;
    if (men_first != prev_last + 2) begin
      errors++;
      $display("FAIL b2b_gap: next mem_en %0d cycles after last, expected 2", men_first - prev_last);
    end
    checks++;
    if (ready_cyc != c1 + 123) begin
      errors++;
      $display("FAIL b2b_ready_time: got +%0d expected +123", ready_cyc - c1);
    end
    check_drained("b2b");
  endtask

  task automatic test_wrap();
    int c0; bit ab;
    do_burst(16'hFFFF, 7'd1, 0, 0, 1'b0, 16'd0, -1, c0, ab);
    checks++;
    if (ready_cyc != c0 + 3 || last_cyc != c0 + 3) begin
      errors++;
      $display("FAIL single_word: ready +%0d last +%0d expected +3 +3", ready_cyc - c0, last_cyc - c0);
    end
    check_drained("single");
    do_burst(16'hFFFF, 7'd2, 0, 0, 1'b0, 16'd0, -1, c0, ab);
    checks++;
    if (men_count != 2 || last_cyc != c0 + 5) begin
      errors++;
      $display("FAIL wrap_burst: reads %0d last +%0d expected 2 +5", men_count, last_cyc - c0);
    end
    check_drained("wrap");
  endtask

  task automatic test_zero_count();
    int bad = 0;
    men_count = 0; ready_cyc = -1;
    @(posedge clk); #1;
    bus.DMA_read = 1'b1; bus.DMA_address = 16'd77; bus.DMA_count = '0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.busy !== 1'b0 || bus.mem_en !== 1'b0 || bus.DMA_ready !== 1'b0) bad++;
    end
    bus.DMA_read = 1'b0;
    checks++;
    if (bad != 0 || men_count != 0 || ready_cyc != -1) begin
      errors++;
      $display("FAIL zero_count: %0d active cycles, %0d reads, ready_seen=%0b expected none", bad, men_count, ready_cyc != -1);
    end
  endtask

  task automatic test_stall();
    int c0; bit ab;
    do_burst(16'd10164, 7'd85, 20, 130, 1'b0, 16'd0, -1, c0, ab);
    checks++;
    if (men_count != 85) begin
      errors++;
      $display("FAIL stall_reads: got %0d expected 85", men_count);
    end
    checks++;
    if (ready_cyc != c0 + 90) begin
      errors++;
      $display("FAIL stall_ready_time: got +%0d expected +90", ready_cyc - c0);
    end
    checks++;
    if (last_cyc != c0 + 177) begin
      errors++;
      $display("FAIL stall_last_time: got +%0d expected +177", last_cyc - c0);
    end
    check_drained("stall");
  endtask

  task automatic test_reset_mid_burst();
    int c0; bit ab;
    do_burst(16'd0, 7'd121, 0, 0, 1'b0, 16'd0, 40, c0, ab);
    checks++;
    if (!ab) begin
      errors++;
      $display("FAIL midreset_reached: word 40 never presented");
    end
    checks++;
    if ({bus.DMA_ready, bus.mem_en, bus.stream_valid, bus.stream_last, bus.busy} !== 5'b0 ||
        {bus.stream_data, bus.stream_index} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: flags=%b data=%h index=%0d expected all 0",
               {bus.DMA_ready, bus.mem_en, bus.stream_valid, bus.stream_last, bus.busy},
               bus.stream_data, bus.stream_index);
    end
    rst = 1'b0;
    check_drained("midreset");
    do_burst(16'd500, 7'd10, 0, 0, 1'b0, 16'd0, -1, c0, ab);
    checks++;
    if (ready_cyc != c0 + 12 || last_cyc != c0 + 21) begin
      errors++;
      $display("FAIL post_reset_burst: ready +%0d last +%0d expected +12 +21", ready_cyc - c0, last_cyc - c0);
    end
    check_drained("post_reset");
  endtask

  task automatic test_random();
    int c0; bit ab;
    logic [MAW-1:0] a;
    logic [LAW-1:0] n;
    for (int r = 0; r < 4; r++) begin
      a = MAW'($urandom_range(0, 65535));
      n = LAW'($urandom_range(1, 127));
      do_burst(a, n, 0, 0, 1'b0, 16'd0, -1, c0, ab);
      checks++;
      if (last_cyc != c0 + 2 * int'(n) + 1) begin
        errors++;
        $display("FAIL random_last_time: addr %h count %0d got +%0d expected +%0d", a, n, last_cyc - c0, 2 * int'(n) + 1);
      end
      check_drained("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_wrap();
    test_zero_count();
    test_stall();
    test_reset_mid_burst();
    test_random();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
